wait_rr_scheduler: RTL and testbench
====================================

WAIT_RR_SCHEDULER -- requirements
Module: wait_rr_scheduler

Interface
REQ-001 SHALL have parameter NREQ, default 4, number of requesters (2..8).
REQ-002 SHALL have parameter DW, default 32, signed data width.
REQ-003 SHALL have parameter CNTW, default 8, width of each wait count.
REQ-004 SHALL have port clk, input, 1: single clock; all state changes on posedge clk.
REQ-005 SHALL have port reset, input, 1: synchronous reset, active-low; reset==0 at a posedge resets the block.
REQ-006 SHALL have port req, input, NREQ: level request per requester.
REQ-007 SHALL have port in_data, input, NREQ*DW: packed signed data; slice i = bits [i*DW +: DW].
REQ-008 SHALL have port in_wait, input, NREQ*CNTW: packed unsigned hold cycles; slice i = bits [i*CNTW +: CNTW].
REQ-009 SHALL have port abort, input, 1: terminates the current hold early.
REQ-010 SHALL have port gnt, output, NREQ: one-hot grant, registered.
REQ-011 SHALL have port out1, output, DW: signed data of the current or most recent grant, registered.
REQ-012 SHALL have port done, output, NREQ: one-cycle completion pulse for the granted index.
REQ-013 SHALL have port aborted, output, 1: one-cycle pulse coincident with an abort release.
REQ-014 SHALL have port busy, output, 1: high while state is HOLD.
REQ-015 SHALL have port state, output, 2: IDLE=0, HOLD=1, RELEASE=2; value 3 is unused.

Function
REQ-016 SHALL implement a three-state FSM: IDLE, HOLD, RELEASE.
REQ-017 SHALL, in IDLE with req!=0 at a posedge, select winner w:
- search order is ptr, ptr+1, ... modulo NREQ;
- w is the first index with req set.
REQ-018 SHALL, at that same edge:
- set gnt to one-hot w, busy to 1, out1 to in_data slice w;
- set cnt to in_wait slice w, or to 1 if that slice is 0;
- set ptr to (w+1) mod NREQ and state to HOLD.
REQ-019 SHALL stay in IDLE with all outputs unchanged when req==0; out1 keeps its last value.
REQ-020 SHALL, in HOLD at each posedge with abort==0:
- if cnt>1, decrement cnt;
- if cnt==1, clear gnt and busy, pulse done[w] for one cycle, go to RELEASE.
REQ-021 SHALL hold gnt high for exactly max(in_wait[w],1) cycles, with in_wait sampled at grant time; later changes to in_wait, in_data or req[w] SHALL NOT affect the active grant.
REQ-022 SHALL, in HOLD with abort==1 at a posedge:
- clear gnt and busy, pulse aborted, leave done at 0, go to RELEASE;
- this applies even when cnt==1, because abort has priority over normal completion.
REQ-023 SHALL ignore abort in IDLE and RELEASE.
REQ-024 SHALL go from RELEASE to IDLE unconditionally after one cycle; done and aborted SHALL deassert there.
REQ-025 SHALL therefore produce a minimum gap of 2 cycles with gnt==0 between consecutive grants.
REQ-026 SHALL count cnt as unsigned CNTW bits; the maximum hold is 2^CNTW-1 cycles and cnt SHALL NOT wrap.
REQ-027 SHALL keep ptr in the range 0..NREQ-1, wrapping from NREQ-1 to 0.

Reset
REQ-028 SHALL, at a posedge with reset==0, set state=IDLE, ptr=0, cnt=0, gnt=0, busy=0, done=0, aborted=0 and out1=0.
REQ-029 SHALL let reset override everything, including mid-HOLD; a grant cut off by reset SHALL produce no done or aborted pulse.
REQ-030 SHALL allow a grant at the first posedge with reset==1 if req!=0.

Verification
REQ-031 Single request: req=4'b0010, in_wait[1]=3, in_data[1]=-5 -> gnt=0010 for exactly 3 cycles, out1=-5 from the grant edge, done[1] pulses once in the cycle after gnt drops, then ptr=2.
REQ-032 Round-robin: req=4'b1111 held, all in_wait=1 -> grant order 0,1,2,3,0, with gnt low for 2 cycles between grants.
REQ-033 Zero wait: req=4'b1000, in_wait[3]=0 -> gnt=1000 for 1 cycle, then done[3] pulses.
REQ-034 Abort: in_wait[0]=10, abort asserted for one cycle on the 4th HOLD cycle -> gnt drops after 4 cycles, aborted=1 for one cycle, done stays 0; abort in IDLE has no effect.
REQ-035 Abort on final cycle: in_wait[2]=2, abort on the 2nd HOLD cycle -> aborted pulses and done[2] stays 0.
REQ-036 Reset mid-HOLD: reset=0 during a grant with in_wait=200 -> at the next posedge all outputs are 0 and state=IDLE; after reset release with req=4'b0110, the next grant goes to index 1.

Source files
------------

// File: rtl/wait_rr_scheduler.sv
// Round-robin scheduler that grants one requester at a time and holds the grant
// for a per-requester wait count, with early abort and a fixed release gap.
module wait_rr_scheduler #(
  parameter int NREQ = 4,
  parameter int DW   = 32,
  parameter int CNTW = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ*DW-1:0]     in_data,
  input  logic [NREQ*CNTW-1:0]   in_wait,
  input  logic                   abort,
  output logic [NREQ-1:0]        gnt,
  output logic [DW-1:0]          out1,
  output logic [NREQ-1:0]        done,
  output logic                   aborted,
  output logic                   busy,
  output logic [1:0]             state
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HOLD    = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [PW-1:0]          ptr_q, ptr_d;
  logic [CNTW-1:0]        cnt_q, cnt_d;
  logic [NREQ-1:0]        gnt_q, gnt_d;
  logic signed [DW-1:0]   out1_q, out1_d;
  logic [NREQ-1:0]        done_q, done_d;
  logic                   aborted_q, aborted_d;
  logic                   busy_q, busy_d;

  logic                   win_found;
  logic [PW-1:0]          win_idx;
  logic [PW-1:0]          cand;
  logic signed [DW-1:0]   sel_data;
  logic [CNTW-1:0]        sel_wait;

  // A zero wait still holds the grant for one cycle.
  function automatic logic [CNTW-1:0] hold_len(input logic [CNTW-1:0] w);
    return (w == '0) ? CNTW'(1) : w;
  endfunction

  // Scan from the farthest candidate back to ptr so the first hit after ptr wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      cand = PW'((int'(ptr_q) + k) % NREQ);
      if (req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin
    sel_data = '0;
    sel_wait = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win_idx == PW'(i)) begin
        sel_data = in_data[i*DW +: DW];
        sel_wait = in_wait[i*CNTW +: CNTW];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      cnt_q     <= '0;
      gnt_q     <= '0;
      out1_q    <= '0;
      done_q    <= '0;
      aborted_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      gnt_q     <= gnt_d;
      out1_q    <= out1_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
      busy_q    <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (win_found) state_d = HOLD;
      HOLD:    if (abort || cnt_q == CNTW'(1)) state_d = RELEASE;
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Abort takes priority over normal completion on the final hold cycle.
  always_comb begin
    gnt_d     = gnt_q;
    out1_d    = out1_q;
    cnt_d     = cnt_q;
    ptr_d     = ptr_q;
    busy_d    = busy_q;
    done_d    = '0;
    aborted_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          gnt_d   = '0;
          gnt_d[win_idx] = 1'b1;
          out1_d  = sel_data;
          cnt_d   = hold_len(sel_wait);
          ptr_d   = (win_idx == PW'(NREQ - 1)) ? '0 : win_idx + PW'(1);
          busy_d  = 1'b1;
        end
      end
      HOLD: begin
        if (abort) begin
          gnt_d     = '0;
          busy_d    = 1'b0;
          aborted_d = 1'b1;
        end else if (cnt_q == CNTW'(1)) begin
          gnt_d  = '0;
          busy_d = 1'b0;
          done_d = gnt_q;
        end else if (cnt_q > CNTW'(1)) begin
          cnt_d = cnt_q - CNTW'(1);
        end
      end
      default: ;
    endcase
  end

  assign gnt     = gnt_q;
  assign out1    = out1_q;
  assign done    = done_q;
  assign aborted = aborted_q;
  assign busy    = busy_q;
  assign state   = state_q;

endmodule

// File: tb/tb_wait_rr_scheduler.sv
// Bench for wait_rr_scheduler: directed scenarios plus random traffic, every
// cycle compared against a transaction-level reference model.
module tb_wait_rr_scheduler;
  localparam int NREQ = 4;
  localparam int DW   = 32;
  localparam int CNTW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 reset;
  logic [NREQ-1:0]      req;
  logic [NREQ*DW-1:0]   in_data;
  logic [NREQ*CNTW-1:0] in_wait;
  logic                 abort;
  logic [NREQ-1:0]      gnt;
  logic [DW-1:0]        out1;
  logic [NREQ-1:0]      done;
  logic                 aborted;
  logic                 busy;
  logic [1:0]           state;

  wait_rr_scheduler #(.NREQ(NREQ), .DW(DW), .CNTW(CNTW)) dut (
    .clk(clk), .reset(reset), .req(req), .in_data(in_data), .in_wait(in_wait),
    .abort(abort), .gnt(gnt), .out1(out1), .done(done), .aborted(aborted),
    .busy(busy), .state(state)
  );

  int n_chk  = 0;
  int n_pass = 0;
  int g_hi   = 0;
  int n_done = 0;
  int n_abrt = 0;

  // Reference model: phase 0 idle, 1 granted, 2 gap cycle after a grant ends.
  int            m_phase = 0;
  int            m_ptr   = 0;
  int            m_owner = 0;
  int            m_len   = 0;
  int            m_held  = 0;
  logic [DW-1:0] m_out1  = '0;
  logic [NREQ-1:0] m_done = '0;
  logic          m_abrt  = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
  endtask

  task automatic model_step();
    int w;
    if (!reset) begin
      m_phase = 0; m_ptr = 0; m_len = 0; m_held = 0;
      m_out1 = '0; m_done = '0; m_abrt = 1'b0;
      return;
    end
    m_done = '0;
    m_abrt = 1'b0;
    if (m_phase == 0) begin
      w = -1;
      for (int k = 0; k < NREQ; k++)
        if (w < 0 && req[(m_ptr + k) % NREQ]) w = (m_ptr + k) % NREQ;
      if (w >= 0) begin
        m_owner = w;
        m_len   = int'(in_wait[w*CNTW +: CNTW]);
        if (m_len == 0) m_len = 1;
        m_held  = 1;
        m_out1  = in_data[w*DW +: DW];
        m_ptr   = (w + 1) % NREQ;
        m_phase = 1;
      end
    end else if (m_phase == 1) begin
      if (abort) begin
        m_abrt = 1'b1; m_phase = 2;
      end else if (m_held == m_len) begin
        m_done[m_owner] = 1'b1; m_phase = 2;
      end else begin
        m_held++;
      end
    end else begin
      m_phase = 0;
    end
  endtask

  task automatic cycle();
    logic [NREQ-1:0] eg;
    @(posedge clk);
    model_step();
    @(negedge clk);
    eg = '0;
    if (m_phase == 1) eg[m_owner] = 1'b1;
    check("gnt", gnt, eg);
    check("out1", out1, m_out1);
    check("done", done, m_done);
    check("aborted", aborted, m_abrt);
    check("busy", busy, m_phase == 1);
    check("state", state, m_phase);
    if (gnt != 0) g_hi++;
    if (done != 0) n_done++;
    if (aborted) n_abrt++;
  endtask

  task automatic set_slot(input int i, input logic [DW-1:0] d, input logic [CNTW-1:0] w);
    in_data[i*DW +: DW]     = d;
    in_wait[i*CNTW +: CNTW] = w;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    cycle();
    reset = 1'b1;
  endtask

  task automatic clear_counts();
    g_hi = 0; n_done = 0; n_abrt = 0;
  endtask

  initial begin
    reset = 1'b0; req = '0; abort = 1'b0; in_data = '0; in_wait = '0;
    cycle();
    cycle();
    reset = 1'b1;

    // Single request with a 3-cycle hold and negative data.
    clear_counts();
    set_slot(1, -32'sd5, 8'd3);
    req = 4'b0010;
    cycle();
    check("single_out1", out1, 32'hFFFF_FFFB);
    req = '0;
    repeat (6) cycle();
    check("single_len", g_hi, 3);
    check("single_done", n_done, 1);

    // Pointer now sits at 2, so a full request set starts from index 2.
    req = 4'b1111;
    for (int i = 0; i < NREQ; i++) set_slot(i, i * 100, 8'd1);
    cycle();
    check("ptr_after_single", gnt, 4'b0100);
    repeat (4) cycle();
    req = '0;
    repeat (3) cycle();

    // Round robin from reset, all waits 1.
    do_reset();
    req = 4'b1111;
    repeat (18) cycle();
    req = '0;
    repeat (3) cycle();

    // Zero wait still gives a one-cycle grant.
    do_reset();
    clear_counts();
    set_slot(3, 32'd77, 8'd0);
    req = 4'b1000;
    cycle();
    req = '0;
    repeat (4) cycle();
    check("zero_len", g_hi, 1);
    check("zero_done", n_done, 1);

    // Abort on the 4th hold cycle of a 10-cycle grant; abort in idle is ignored.
    do_reset();
    clear_counts();
    set_slot(0, 32'd9, 8'd10);
    req = 4'b0001;
    cycle();
    req = '0;
    repeat (3) cycle();
    abort = 1'b1;
    cycle();
    abort = 1'b0;
    repeat (4) cycle();
    abort = 1'b1;
    repeat (3) cycle();
    abort = 1'b0;
    check("abort_len", g_hi, 4);
    check("abort_pulse", n_abrt, 1);
    check("abort_nodone", n_done, 0);

    // Abort on the final hold cycle wins over completion.
    do_reset();
    clear_counts();
    set_slot(2, 32'd5, 8'd2);
    req = 4'b0100;
    cycle();
    req = '0;
    cycle();
    abort = 1'b1;
    cycle();
    abort = 1'b0;
    repeat (3) cycle();
    check("abort_last_pulse", n_abrt, 1);
    check("abort_last_nodone", n_done, 0);

    // Reset in the middle of a long hold.
    do_reset();
    clear_counts();
    set_slot(0, 32'd1234, 8'd200);
    req = 4'b0001;
    cycle();
    req = '0;
    repeat (5) cycle();
    reset = 1'b0;
    cycle();
    reset = 1'b1;
    req = 4'b0110;
    cycle();
    check("post_reset_gnt", gnt, 4'b0010);
    req = '0;
    repeat (4) cycle();
    check("reset_no_pulse", n_done + n_abrt, 1);

    // Random traffic, including mid-grant input changes.
    for (int c = 0; c < 4000; c++) begin
      reset = ($urandom_range(0, 199) != 0);
      req   = ($urandom_range(0, 3) == 0) ? '0 : NREQ'($urandom);
      abort = ($urandom_range(0, 9) == 0);
      for (int i = 0; i < NREQ; i++)
        set_slot(i, $urandom, ($urandom_range(0, 15) == 0) ? CNTW'($urandom) : CNTW'($urandom_range(0, 5)));
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
